// File: rtl/i2c_master_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : i2c_master_gen
// Description : I2C master transaction generator: START, 7-bit address + R/W,
//               NBYTES data bytes (write or read) with ACK handling, STOP.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_gen #(
    parameter int NBYTES  = 2,
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            i2c_addr,
    input  logic                  rnw,
    input  logic [8*NBYTES-1:0]   wr_data,
    input  logic                  start_stb,
    output logic [8*NBYTES-1:0]   rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  nack,
    input  logic                  sda_in,
    output logic                  sda_out,
    output logic                  sda_oe,
    output logic                  scl
);

    localparam int c_W  = 8 * NBYTES;
    localparam int c_T  = 4 * CLK_DIV;
    localparam int c_CW = $clog2(c_T);
    localparam int c_BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [c_CW-1:0] c_BIT_LAST   = c_CW'(c_T - 1);
    localparam logic [c_CW-1:0] c_START_LAST = c_CW'(2 * CLK_DIV - 1);
    localparam logic [c_CW-1:0] c_PH1        = c_CW'(CLK_DIV);
    localparam logic [c_CW-1:0] c_PH2        = c_CW'(2 * CLK_DIV);
    localparam logic [c_CW-1:0] c_PH3        = c_CW'(3 * CLK_DIV);
    localparam logic [c_BW-1:0] c_BYTE_LAST  = c_BW'(NBYTES - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_START    = 3'd1;
    localparam logic [2:0] c_ST_ADDR     = 3'd2;
    localparam logic [2:0] c_ST_ADDR_ACK = 3'd3;
    localparam logic [2:0] c_ST_DATA     = 3'd4;
    localparam logic [2:0] c_ST_DATA_ACK = 3'd5;
    localparam logic [2:0] c_ST_STOP     = 3'd6;

    logic [2:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit;
    logic [c_BW-1:0] r_byte;
    logic            r_rnw;
    logic [7:0]      r_addr_sh;
    logic [c_W-1:0]  r_tx;
    logic [c_W-1:0]  r_rx;
    logic [c_W-1:0]  r_rd_data;
    logic            r_nack;
    logic            r_done;
    logic            r_busy;
    logic            r_scl;
    logic            r_sda_out;
    logic            r_sda_oe;

    logic            w_last;
    logic            w_sample;
    logic            w_accept;
    logic [2:0]      w_state_nx;
    logic [c_CW-1:0] w_cnt_nx;
    logic [2:0]      w_bit_nx;
    logic [c_BW-1:0] w_byte_nx;
    logic [7:0]      w_addr_nx;
    logic [c_W-1:0]  w_tx_nx;
    logic            w_scl_nx;
    logic            w_oe_nx;
    logic            w_out_nx;
    logic            w_bit_scl;

    assign w_last   = (r_state == c_ST_START) ? (r_cnt == c_START_LAST) : (r_cnt == c_BIT_LAST);
    assign w_sample = (r_cnt == c_PH3);
    // The done cycle still counts as part of the transaction for start requests
    assign w_accept = (r_state == c_ST_IDLE) && start_stb && !r_done;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        w_byte_nx  = r_byte;
        w_addr_nx  = r_addr_sh;
        w_tx_nx    = r_tx;
        if (r_state == c_ST_IDLE) begin
            if (w_accept) begin
                w_state_nx = c_ST_START;
                w_cnt_nx   = '0;
                w_addr_nx  = {i2c_addr, rnw};
                w_tx_nx    = wr_data;
            end
        end else if (!w_last) begin
            w_cnt_nx = r_cnt + 1'b1;
        end else begin
            w_cnt_nx = '0;
            case (r_state)
                c_ST_START: begin
                    w_state_nx = c_ST_ADDR;
                    w_bit_nx   = 3'd0;
                end
                c_ST_ADDR: begin
                    w_addr_nx = {r_addr_sh[6:0], 1'b0};
                    if (r_bit == 3'd7) w_state_nx = c_ST_ADDR_ACK;
                    else               w_bit_nx   = r_bit + 1'b1;
                end
                c_ST_ADDR_ACK: begin
                    if (r_nack) begin
                        w_state_nx = c_ST_STOP;
                    end else begin
                        w_state_nx = c_ST_DATA;
                        w_bit_nx   = 3'd0;
                        w_byte_nx  = '0;
                    end
                end
                c_ST_DATA: begin
                    if (!r_rnw) w_tx_nx = {r_tx[c_W-2:0], 1'b0};
                    if (r_bit == 3'd7) w_state_nx = c_ST_DATA_ACK;
                    else               w_bit_nx   = r_bit + 1'b1;
                end
                c_ST_DATA_ACK: begin
                    if (r_nack || (r_byte == c_BYTE_LAST)) begin
                        w_state_nx = c_ST_STOP;
                    end else begin
                        w_state_nx = c_ST_DATA;
                        w_bit_nx   = 3'd0;
                        w_byte_nx  = r_byte + 1'b1;
                    end
                end
                default: w_state_nx = c_ST_IDLE;
            endcase
        end
    end

    // Line outputs are decoded from the upcoming position so they are registered
    assign w_bit_scl = (w_cnt_nx >= c_PH2);

    always_comb begin
        w_scl_nx = 1'b1;
        w_oe_nx  = 1'b0;
        w_out_nx = 1'b1;
        case (w_state_nx)
            c_ST_START: begin
                w_oe_nx  = 1'b1;
                w_out_nx = (w_cnt_nx < c_PH1);
            end
            c_ST_ADDR: begin
                w_scl_nx = w_bit_scl;
                w_oe_nx  = 1'b1;
                w_out_nx = w_addr_nx[7];
            end
            c_ST_ADDR_ACK: w_scl_nx = w_bit_scl;
            c_ST_DATA: begin
                w_scl_nx = w_bit_scl;
                w_oe_nx  = !r_rnw;
                w_out_nx = r_rnw | w_tx_nx[c_W-1];
            end
            c_ST_DATA_ACK: begin
                w_scl_nx = w_bit_scl;
                if (r_rnw) begin
                    w_oe_nx  = 1'b1;
                    w_out_nx = (w_byte_nx == c_BYTE_LAST);
                end
            end
            c_ST_STOP: begin
                w_scl_nx = w_bit_scl;
                w_oe_nx  = 1'b1;
                w_out_nx = (w_cnt_nx >= c_PH3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= 3'd0;
            r_byte    <= '0;
            r_rnw     <= 1'b0;
            r_addr_sh <= 8'd0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rd_data <= '0;
            r_nack    <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_out <= 1'b1;
            r_sda_oe  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_bit     <= w_bit_nx;
            r_byte    <= w_byte_nx;
            r_addr_sh <= w_addr_nx;
            r_tx      <= w_tx_nx;
            r_scl     <= w_scl_nx;
            r_sda_oe  <= w_oe_nx;
            r_sda_out <= w_out_nx;
            r_busy    <= (w_state_nx != c_ST_IDLE);
            r_done    <= (r_state == c_ST_STOP) && w_last;
            if (w_accept) begin
                r_rnw  <= rnw;
                r_nack <= 1'b0;
            end
            if (w_sample) begin
                if ((r_state == c_ST_ADDR_ACK) && sda_in)
                    r_nack <= 1'b1;
                if ((r_state == c_ST_DATA_ACK) && !r_rnw && sda_in)
                    r_nack <= 1'b1;
                if ((r_state == c_ST_DATA) && r_rnw)
                    r_rx <= {r_rx[c_W-2:0], sda_in};
            end
            if ((r_state == c_ST_STOP) && w_last && r_rnw && !r_nack)
                r_rd_data <= r_rx;
        end
    end

    assign rd_data = r_rd_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign nack    = r_nack;
    assign sda_out = r_sda_out;
    assign sda_oe  = r_sda_oe;
    assign scl     = r_scl;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_i2c_master_gen
// Description : Directed self-checking bench for i2c_master_gen (default and
//               NBYTES=1/CLK_DIV=1 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_master_gen;

    localparam int CD = 4;
    localparam int T  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [6:0]  i2c_addr;
    logic        rnw;
    logic [15:0] wr_data;
    logic        start_stb;
    logic [15:0] rd_data;
    logic        busy, done, nack, sda_in, sda_out, sda_oe, scl;
    logic        slave_drv;

    logic [6:0]  b_addr;
    logic        b_rnw;
    logic [7:0]  b_wr;
    logic        b_start;
    logic [7:0]  b_rd;
    logic        b_busy, b_done, b_nack, b_sda_in, b_sda_out, b_sda_oe, b_scl;
    logic        b_slave;

    // Open-drain bus: slave can only pull low
    assign sda_in   = (sda_oe ? sda_out : 1'b1) & slave_drv;
    assign b_sda_in = (b_sda_oe ? b_sda_out : 1'b1) & b_slave;

    i2c_master_gen #(.NBYTES(2), .CLK_DIV(4)) u_dut (
        .clk(clk), .reset(reset), .i2c_addr(i2c_addr), .rnw(rnw), .wr_data(wr_data),
        .start_stb(start_stb), .rd_data(rd_data), .busy(busy), .done(done), .nack(nack),
        .sda_in(sda_in), .sda_out(sda_out), .sda_oe(sda_oe), .scl(scl)
    );

    i2c_master_gen #(.NBYTES(1), .CLK_DIV(1)) u_dut_b (
        .clk(clk), .reset(reset), .i2c_addr(b_addr), .rnw(b_rnw), .wr_data(b_wr),
        .start_stb(b_start), .rd_data(b_rd), .busy(b_busy), .done(b_done), .nack(b_nack),
        .sda_in(b_sda_in), .sda_out(b_sda_out), .sda_oe(b_sda_oe), .scl(b_scl)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] tr    [0:1023];  // {scl, sda_oe, sda_out} per cycle from busy rise
    logic       sdrv  [0:1023];
    logic [1:0] ebits [0:26];    // {oe, out} expected at each bit's sample point

    task automatic fill_sdrv(input logic v);
        for (int i = 0; i < 1024; i++) sdrv[i] = v;
    endtask

    task automatic set_bit_drv(input int k, input logic v);
        for (int i = 0; i < T; i++) sdrv[2*CD + k*T + i] = v;
    endtask

    task automatic start_txn(input logic [6:0] a, input logic r, input logic [15:0] wd);
        i2c_addr  = a;
        rnw       = r;
        wr_data   = wd;
        start_stb = 1'b1;
        @(posedge clk); #1;
        start_stb = 1'b0;
    endtask

    task automatic capture(input int p0, input int p1, output int done_at);
        done_at = -1;
        for (int c = 0; c < 1000; c++) begin
            slave_drv = sdrv[c];
            tr[c]     = {scl, sda_oe, sda_out};
            if (done === 1'b1) begin
                done_at = c;
                break;
            end
            start_stb = (c == p0) || (c == p1);
            if (start_stb) begin
                i2c_addr = 7'h7F;
                rnw      = 1'b1;
                wr_data  = 16'hFFFF;
            end
            @(posedge clk); #1;
        end
        start_stb = 1'b0;
        slave_drv = 1'b1;
    endtask

    task automatic build_write_ebits(input logic [23:0] seq);
        for (int k = 0; k < 27; k++) begin
            if ((k % 9) < 8) ebits[k] = {1'b1, seq[23 - ((k / 9) * 8 + (k % 9))]};
            else             ebits[k] = 2'b00;
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0; start_stb = 1'b0; slave_drv = 1'b1; b_start = 1'b0; b_slave = 1'b1;
        i2c_addr = 7'h00; rnw = 1'b0; wr_data = 16'h0;
        b_addr = 7'h00; b_rnw = 1'b0; b_wr = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({scl, sda_oe, sda_out, busy, done, nack} !== 6'b101000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 101000", {scl, sda_oe, sda_out, busy, done, nack});
        end
        n_cmp++;
        if (rd_data !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_rd_data: got %h want 0000", rd_data);
        end
        #2 reset = 1'b1;
        @(posedge clk); #1;
        start_txn(7'h50, 1'b0, 16'hA55A);
        repeat (26) @(posedge clk);
        #1;
        n_cmp++;
        if ({scl, sda_oe} !== 2'b01) begin
            n_err++;
            $display("FAIL mid_addr_state: got %b want 01", {scl, sda_oe});
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({scl, sda_oe, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_async: got %b want 100", {scl, sda_oe, busy});
        end
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (scl !== 1'b1 || sda_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_write();
        int d, idx;
        logic [1:0] got2;
        fill_sdrv(1'b1);
        set_bit_drv(8, 1'b0); set_bit_drv(17, 1'b0); set_bit_drv(26, 1'b0);
        build_write_ebits({8'hA0, 8'hA5, 8'h5A});
        start_txn(7'h50, 1'b0, 16'hA55A);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_rise: got %b want 1", busy); end
        capture(-1, -1, d);
        n_cmp++;
        if ({tr[0], tr[CD], tr[2*CD-1]} !== 9'b111_110_110) begin
            n_err++;
            $display("FAIL wr_start_shape: got %b want 111110110", {tr[0], tr[CD], tr[2*CD-1]});
        end
        for (int k = 0; k < 27; k++) begin
            idx  = 2*CD + k*T;
            got2 = tr[idx + 3*CD][1:0];
            if (!ebits[k][1]) got2[0] = 1'b0;
            n_cmp++;
            if (got2 !== ebits[k]) begin
                n_err++;
                $display("FAIL wr_bit%0d: got oe/out %b want %b", k, got2, ebits[k]);
            end
            n_cmp++;
            if ({tr[idx][2], tr[idx + 2*CD][2]} !== 2'b01) begin
                n_err++;
                $display("FAIL wr_scl_bit%0d: got %b want 01", k, {tr[idx][2], tr[idx + 2*CD][2]});
            end
        end
        n_cmp++;
        if ({tr[440], tr[448], tr[452]} !== 9'b010_110_111) begin
            n_err++;
            $display("FAIL wr_stop_shape: got %b want 010110111", {tr[440], tr[448], tr[452]});
        end
        n_cmp++;
        if (d !== 456) begin n_err++; $display("FAIL wr_latency: got %0d want 456", d); end
        n_cmp++;
        if ({busy, nack, rd_data} !== {2'b00, 16'h0000}) begin
            n_err++;
            $display("FAIL wr_end_state: got %b/%b/%h want 0/0/0000", busy, nack, rd_data);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL wr_done_width: got %b want 0", done); end
    endtask

    task automatic test_read();
        int d;
        logic [1:0] got2;
        logic [15:0] rdv;
        logic [7:0] ab;
        rdv = 16'h3CC3;
        ab  = 8'h47;
        fill_sdrv(1'b1);
        set_bit_drv(8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            set_bit_drv(9 + i, rdv[15 - i]);
            set_bit_drv(18 + i, rdv[7 - i]);
        end
        for (int k = 0; k < 27; k++) ebits[k] = (k < 8) ? {1'b1, ab[7 - k]} : 2'b00;
        ebits[17] = 2'b10;
        ebits[26] = 2'b11;
        start_txn(7'h23, 1'b1, 16'h0000);
        capture(-1, -1, d);
        for (int k = 0; k < 27; k++) begin
            got2 = tr[2*CD + k*T + 3*CD][1:0];
            if (!ebits[k][1]) got2[0] = 1'b0;
            n_cmp++;
            if (got2 !== ebits[k]) begin
                n_err++;
                $display("FAIL rd_bit%0d: got oe/out %b want %b", k, got2, ebits[k]);
            end
        end
        n_cmp++;
        if (d !== 456) begin n_err++; $display("FAIL rd_latency: got %0d want 456", d); end
        n_cmp++;
        if (rd_data !== 16'h3CC3) begin n_err++; $display("FAIL rd_data: got %h want 3cc3", rd_data); end
        n_cmp++;
        if (nack !== 1'b0) begin n_err++; $display("FAIL rd_nack: got %b want 0", nack); end
        n_cmp++;
        if ({tr[440], tr[452]} !== 6'b010_111) begin
            n_err++;
            $display("FAIL rd_stop_shape: got %b want 010111", {tr[440], tr[452]});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_addr_nack();
        int d;
        logic [7:0] ab;
        ab = 8'h22;
        fill_sdrv(1'b1);
        start_txn(7'h11, 1'b0, 16'hBEEF);
        capture(-1, -1, d);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (tr[2*CD + k*T + 3*CD][1:0] !== {1'b1, ab[7 - k]}) begin
                n_err++;
                $display("FAIL an_addr_bit%0d: got %b want %b", k, tr[2*CD + k*T + 3*CD][1:0], {1'b1, ab[7 - k]});
            end
        end
        n_cmp++;
        if (tr[2*CD + 8*T + 3*CD][1] !== 1'b0) begin
            n_err++;
            $display("FAIL an_ack_release: got oe %b want 0", tr[2*CD + 8*T + 3*CD][1]);
        end
        n_cmp++;
        if ({tr[152], tr[160], tr[164]} !== 9'b010_110_111) begin
            n_err++;
            $display("FAIL an_stop_shape: got %b want 010110111", {tr[152], tr[160], tr[164]});
        end
        n_cmp++;
        if (d !== 168) begin n_err++; $display("FAIL an_latency: got %0d want 168", d); end
        n_cmp++;
        if ({nack, rd_data} !== {1'b1, 16'h3CC3}) begin
            n_err++;
            $display("FAIL an_nack_rd: got %b/%h want 1/3cc3", nack, rd_data);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        logic [1:0] got2;
        @(posedge clk); #1;
        fill_sdrv(1'b1);
        set_bit_drv(8, 1'b0); set_bit_drv(17, 1'b0); set_bit_drv(26, 1'b0);
        build_write_ebits({8'h54, 8'h12, 8'h34});
        start_txn(7'h2A, 1'b0, 16'h1234);
        n_cmp++;
        if ({busy, nack} !== 2'b10) begin
            n_err++;
            $display("FAIL bb_accept_clear: got busy/nack %b want 10", {busy, nack});
        end
        capture(10, 455, d);
        n_cmp++;
        if (d !== 456) begin n_err++; $display("FAIL bb_latency: got %0d want 456", d); end
        for (int k = 0; k < 27; k++) begin
            got2 = tr[2*CD + k*T + 3*CD][1:0];
            if (!ebits[k][1]) got2[0] = 1'b0;
            n_cmp++;
            if (got2 !== ebits[k]) begin
                n_err++;
                $display("FAIL bb_bit%0d: got oe/out %b want %b", k, got2, ebits[k]);
            end
        end
        n_cmp++;
        if (nack !== 1'b0) begin n_err++; $display("FAIL bb_nack: got %b want 0", nack); end
        i2c_addr = 7'h7F; rnw = 1'b1; start_stb = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL bb_done_cycle_start: got busy %b want 0", busy); end
        i2c_addr = 7'h11; rnw = 1'b0; wr_data = 16'h0000;
        @(posedge clk); #1;
        start_stb = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL bb_after_done_start: got busy %b want 1", busy); end
        fill_sdrv(1'b1);
        capture(-1, -1, d);
        n_cmp++;
        if ({d == 168, nack} !== 2'b11) begin
            n_err++;
            $display("FAIL bb_second_txn: got latency %0d nack %b want 168/1", d, nack);
        end
        n_cmp++;
        if (tr[2*CD + 2*T + 3*CD][1:0] !== 2'b11) begin
            n_err++;
            $display("FAIL bb_second_addr: got %b want 11", tr[2*CD + 2*T + 3*CD][1:0]);
        end
    endtask

    task automatic test_nbytes1();
        int d;
        logic [23:0] seq;
        seq = {8'h10, 8'h7F, 8'h00};
        d = -1;
        b_addr = 7'h08; b_rnw = 1'b0; b_wr = 8'h7F; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        n_cmp++;
        if (b_busy !== 1'b1) begin n_err++; $display("FAIL n1_busy_rise: got %b want 1", b_busy); end
        for (int c = 0; c < 200; c++) begin
            b_slave = (c >= 2 + 8*4 && c < 2 + 9*4) ? 1'b0 : 1'b1;
            tr[c]   = {b_scl, b_sda_oe, b_sda_out};
            if (b_done === 1'b1) begin
                d = c;
                break;
            end
            @(posedge clk); #1;
        end
        b_slave = 1'b1;
        n_cmp++;
        if (d !== 78) begin n_err++; $display("FAIL n1_latency: got %0d want 78", d); end
        n_cmp++;
        if ({b_nack, b_rd} !== {1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL n1_nack_rd: got %b/%h want 1/00", b_nack, b_rd);
        end
        for (int k = 0; k < 17; k++) begin
            if (k != 8) begin
                n_cmp++;
                if (tr[2 + 4*k + 3][1:0] !== {1'b1, seq[23 - ((k / 9) * 8 + (k % 9))]}) begin
                    n_err++;
                    $display("FAIL n1_bit%0d: got %b want %b", k, tr[2 + 4*k + 3][1:0],
                             {1'b1, seq[23 - ((k / 9) * 8 + (k % 9))]});
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({tr[2+4*k][2], tr[3+4*k][2], tr[4+4*k][2], tr[5+4*k][2]} !== 4'b0011) begin
                n_err++;
                $display("FAIL n1_scl_period%0d: got %b want 0011", k,
                         {tr[2+4*k][2], tr[3+4*k][2], tr[4+4*k][2], tr[5+4*k][2]});
            end
        end
        n_cmp++;
        if ({tr[2+17*4][1], tr[74], tr[76], tr[77]} !== 10'b0_010_110_111) begin
            n_err++;
            $display("FAIL n1_ack_stop: got %b want 0010110111", {tr[2+17*4][1], tr[74], tr[76], tr[77]});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_back_to_back();
        test_nbytes1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
